// File: rtl/branch_predict_unit.sv
// Direct-mapped branch target buffer with 2-bit counters, plus execute-stage
// branch resolution, redirect generation and performance counters.
module branch_predict_unit #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [PC_W-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [31:0]     pred_target,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] Cur_PC,
    input  logic [31:0]     Imm,
    input  logic            Branch,
    input  logic            JalrSel,
    input  logic            HaltSel,
    input  logic [31:0]     AluResult,
    input  logic            ex_pred_taken,
    input  logic [31:0]     ex_pred_target,
    output logic [31:0]     PC_Imm,
    output logic [31:0]     PC_Four,
    output logic [31:0]     BrPC,
    output logic            PcSel,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];
    logic [31:0]      br_count_q, br_count_d;
    logic [31:0]      mispred_count_q, mispred_count_d;

    logic [31:0]      pcf, fetch_pcf;
    logic [IDX_W-1:0] fidx, uidx;
    logic [TAG_W-1:0] ftag, utag;
    logic             fhit, uhit;
    logic             actual_taken, mispredict, do_update;
    logic [31:0]      actual_target;

    assign pcf       = {{(32-PC_W){1'b0}}, Cur_PC};
    assign fetch_pcf = {{(32-PC_W){1'b0}}, fetch_pc};

    assign fidx = fetch_pc[IDX_W+1:2];
    assign ftag = fetch_pc[PC_W-1:IDX_W+2];
    assign uidx = Cur_PC[IDX_W+1:2];
    assign utag = Cur_PC[PC_W-1:IDX_W+2];

    // Prediction reads only registered state, so a same-cycle update is not visible.
    assign fhit        = valid_q[fidx] && (tag_q[fidx] == ftag);
    assign pred_taken  = fhit && ctr_q[fidx][1];
    assign pred_target = pred_taken ? target_q[fidx] : fetch_pcf + 32'd4;

    assign PC_Imm  = HaltSel ? pcf : pcf + Imm;
    assign PC_Four = HaltSel ? pcf : pcf + 32'd4;

    always_comb begin
        actual_taken = HaltSel || JalrSel || (Branch && AluResult[0]);
        if (HaltSel)
            actual_target = pcf;
        else if (JalrSel)
            actual_target = AluResult;
        else if (Branch && AluResult[0])
            actual_target = PC_Imm;
        else
            actual_target = PC_Four;
    end

    assign mispredict = ex_valid && ((actual_taken != ex_pred_taken) ||
                        (actual_taken && (ex_pred_target != actual_target)));
    assign PcSel      = (ex_valid && HaltSel) || mispredict;
    assign BrPC       = actual_target;

    assign do_update = ex_valid && !HaltSel && (Branch || JalrSel);
    assign uhit      = valid_q[uidx] && (tag_q[uidx] == utag);

    always_comb begin
        valid_d         = valid_q;
        tag_d           = tag_q;
        target_d        = target_q;
        ctr_d           = ctr_q;
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;

        if (do_update) begin
            br_count_d = br_count_q + 32'd1;
            if (uhit) begin
                if (JalrSel)
                    ctr_d[uidx] = 2'b11;
                else if (actual_taken && (ctr_q[uidx] != 2'b11))
                    ctr_d[uidx] = ctr_q[uidx] + 2'd1;
                else if (!actual_taken && (ctr_q[uidx] != 2'b00))
                    ctr_d[uidx] = ctr_q[uidx] - 2'd1;
                if (actual_taken)
                    target_d[uidx] = actual_target;
            end else if (actual_taken) begin
                valid_d[uidx]  = 1'b1;
                tag_d[uidx]    = utag;
                target_d[uidx] = actual_target;
                ctr_d[uidx]    = JalrSel ? 2'b11 : 2'b10;
            end
        end

        // A halt reports as mispredicted but must leave the statistics frozen.
        if (mispredict && !HaltSel)
            mispred_count_d = mispred_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            valid_q         <= valid_d;
            tag_q           <= tag_d;
            target_q        <= target_d;
            ctr_q           <= ctr_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed vector bench for branch_predict_unit: combinational outputs are
// checked mid-cycle, performance counters just after the following edge.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [8:0]  fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [8:0]  Cur_PC;
    logic [31:0] Imm;
    logic        Branch, JalrSel, HaltSel;
    logic [31:0] AluResult;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] PC_Imm, PC_Four, BrPC;
    logic        PcSel;
    logic [31:0] br_count, mispred_count;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predict_unit #(.PC_W(9), .ENTRIES(16)) dut (
        .clk(clk), .reset_n(reset_n), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .Cur_PC(Cur_PC), .Imm(Imm),
        .Branch(Branch), .JalrSel(JalrSel), .HaltSel(HaltSel),
        .AluResult(AluResult), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .PC_Imm(PC_Imm), .PC_Four(PC_Four),
        .BrPC(BrPC), .PcSel(PcSel), .br_count(br_count),
        .mispred_count(mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  fpc;
        logic        exv;
        logic [8:0]  cpc;
        logic [31:0] imm;
        logic        br, jalr, halt;
        logic [31:0] alu;
        logic        expt;
        logic [31:0] exptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_pcsel;
        logic [31:0] e_brpc, e_pcimm, e_pcfour, e_br, e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [8:0] fpc, input logic exv, input logic [8:0] cpc,
        input logic [31:0] imm, input logic br, input logic jalr,
        input logic halt, input logic [31:0] alu, input logic expt,
        input logic [31:0] exptgt, input logic e_pt, input logic [31:0] e_ptgt,
        input logic e_pcsel, input logic [31:0] e_brpc, input logic [31:0] e_pcimm,
        input logic [31:0] e_pcfour, input logic [31:0] e_br, input logic [31:0] e_mis);
        vec_t v;
        v.fpc = fpc; v.exv = exv; v.cpc = cpc; v.imm = imm; v.br = br;
        v.jalr = jalr; v.halt = halt; v.alu = alu; v.expt = expt;
        v.exptgt = exptgt; v.e_pt = e_pt; v.e_ptgt = e_ptgt;
        v.e_pcsel = e_pcsel; v.e_brpc = e_brpc; v.e_pcimm = e_pcimm;
        v.e_pcfour = e_pcfour; v.e_br = e_br; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle(input logic [8:0] fpc);
        fetch_pc = fpc; ex_valid = 1'b0; Cur_PC = '0; Imm = '0;
        Branch = 1'b0; JalrSel = 1'b0; HaltSel = 1'b0; AluResult = '0;
        ex_pred_taken = 1'b0; ex_pred_target = '0;
    endtask

    initial begin
        reset_n = 1'b0;
        drive_idle(9'h040);
        repeat (2) @(posedge clk);
        #1;
        chk("reset br_count", br_count, 32'd0);
        chk("reset mispred_count", mispred_count, 32'd0);
        chk("reset pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("reset pred_target", pred_target, 32'h44);
        reset_n = 1'b1;

        //                fpc   exv cpc    imm     br jr ht alu    expt extgt  e_pt e_ptgt e_sel e_brpc e_pcimm e_pc4 e_br e_mis
        vecs.push_back(mk(9'h040,0, 9'h000,32'h0,  0, 0, 0, 32'h0, 0, 32'h0,  0, 32'h44, 0, 32'h4,  32'h0,  32'h4,  0, 0));
        vecs.push_back(mk(9'h040,1, 9'h040,32'h20, 1, 0, 0, 32'h1, 0, 32'h44, 0, 32'h44, 1, 32'h60, 32'h60, 32'h44, 1, 1));
        vecs.push_back(mk(9'h040,0, 9'h000,32'h0,  0, 0, 0, 32'h0, 0, 32'h0,  1, 32'h60, 0, 32'h4,  32'h0,  32'h4,  1, 1));
        vecs.push_back(mk(9'h040,1, 9'h040,32'h20, 1, 0, 0, 32'h0, 1, 32'h60, 1, 32'h60, 1, 32'h44, 32'h60, 32'h44, 2, 2));
        vecs.push_back(mk(9'h040,1, 9'h040,32'h20, 1, 0, 0, 32'h0, 0, 32'h44, 0, 32'h44, 0, 32'h44, 32'h60, 32'h44, 3, 2));
        vecs.push_back(mk(9'h040,0, 9'h000,32'h0,  0, 0, 0, 32'h0, 0, 32'h0,  0, 32'h44, 0, 32'h4,  32'h0,  32'h4,  3, 2));
        vecs.push_back(mk(9'h040,1, 9'h040,32'h20, 1, 0, 0, 32'h1, 0, 32'h44, 0, 32'h44, 1, 32'h60, 32'h60, 32'h44, 4, 3));
        vecs.push_back(mk(9'h040,0, 9'h000,32'h0,  0, 0, 0, 32'h0, 0, 32'h0,  0, 32'h44, 0, 32'h4,  32'h0,  32'h4,  4, 3));
        vecs.push_back(mk(9'h080,1, 9'h080,32'h0,  0, 1, 0, 32'h18,0, 32'h84, 0, 32'h84, 1, 32'h18, 32'h80, 32'h84, 5, 4));
        vecs.push_back(mk(9'h080,1, 9'h080,32'h0,  0, 1, 0, 32'h1C,1, 32'h18, 1, 32'h18, 1, 32'h1C, 32'h80, 32'h84, 6, 5));
        vecs.push_back(mk(9'h080,0, 9'h000,32'h0,  0, 0, 0, 32'h0, 0, 32'h0,  1, 32'h1C, 0, 32'h4,  32'h0,  32'h4,  6, 5));
        vecs.push_back(mk(9'h040,0, 9'h000,32'h0,  0, 0, 0, 32'h0, 0, 32'h0,  0, 32'h44, 0, 32'h4,  32'h0,  32'h4,  6, 5));
        vecs.push_back(mk(9'h080,1, 9'h0F0,32'h100,1, 0, 1, 32'h1C,0, 32'hF4, 1, 32'h1C, 1, 32'hF0, 32'hF0, 32'hF0, 6, 5));
        vecs.push_back(mk(9'h0F0,0, 9'h000,32'h0,  0, 0, 0, 32'h0, 0, 32'h0,  0, 32'hF4, 0, 32'h4,  32'h0,  32'h4,  6, 5));
        vecs.push_back(mk(9'h080,0, 9'h000,32'h0,  0, 0, 0, 32'h0, 0, 32'h0,  1, 32'h1C, 0, 32'h4,  32'h0,  32'h4,  6, 5));
        vecs.push_back(mk(9'h000,1, 9'h080,32'h0,  0, 1, 0, 32'h1C,1, 32'h1C, 0, 32'h4,  0, 32'h1C, 32'h80, 32'h84, 7, 5));
        vecs.push_back(mk(9'h040,0, 9'h040,32'h20, 1, 0, 0, 32'h1, 0, 32'h0,  0, 32'h44, 0, 32'h60, 32'h60, 32'h44, 7, 5));

        foreach (vecs[i]) begin
            fetch_pc = vecs[i].fpc; ex_valid = vecs[i].exv; Cur_PC = vecs[i].cpc;
            Imm = vecs[i].imm; Branch = vecs[i].br; JalrSel = vecs[i].jalr;
            HaltSel = vecs[i].halt; AluResult = vecs[i].alu;
            ex_pred_taken = vecs[i].expt; ex_pred_target = vecs[i].exptgt;
            @(negedge clk);
            chk($sformatf("v%0d pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
            chk($sformatf("v%0d pred_target", i), pred_target, vecs[i].e_ptgt);
            chk($sformatf("v%0d PcSel", i), {31'd0, PcSel}, {31'd0, vecs[i].e_pcsel});
            chk($sformatf("v%0d BrPC", i), BrPC, vecs[i].e_brpc);
            chk($sformatf("v%0d PC_Imm", i), PC_Imm, vecs[i].e_pcimm);
            chk($sformatf("v%0d PC_Four", i), PC_Four, vecs[i].e_pcfour);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d br_count", i), br_count, vecs[i].e_br);
            chk($sformatf("v%0d mispred_count", i), mispred_count, vecs[i].e_mis);
        end

        // Reset lands on a cycle that would otherwise allocate a taken branch.
        reset_n = 1'b0;
        fetch_pc = 9'h080; ex_valid = 1'b1; Cur_PC = 9'h044; Imm = 32'h10;
        Branch = 1'b1; JalrSel = 1'b0; HaltSel = 1'b0; AluResult = 32'h1;
        ex_pred_taken = 1'b0; ex_pred_target = 32'h48;
        @(negedge clk);
        chk("rst-upd PcSel", {31'd0, PcSel}, 32'd1);
        chk("rst-upd BrPC", BrPC, 32'h54);
        chk("rst-upd pred_taken pre-edge", {31'd0, pred_taken}, 32'd1);
        chk("rst-upd pred_target pre-edge", pred_target, 32'h1C);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive_idle(9'h044);
        chk("rst-upd br_count", br_count, 32'd0);
        chk("rst-upd mispred_count", mispred_count, 32'd0);
        #1;
        chk("rst-upd no alloc pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst-upd no alloc pred_target", pred_target, 32'h48);
        fetch_pc = 9'h080;
        #1;
        chk("rst-upd cleared pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst-upd cleared pred_target", pred_target, 32'h84);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter PC_W, default 9, meaning the program-counter width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, meaning the predictor table depth; it is a power of 2, IDX_W = log2(ENTRIES), and PC_W >= IDX_W+3.
REQ-003 SHALL have port clk, input, 1, the single clock; every state element updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, the reset; it is synchronous and active-low.
REQ-005 SHALL have port fetch_pc, input, PC_W, the PC being fetched this cycle.
REQ-006 SHALL have port pred_taken, output, 1, the prediction for fetch_pc.
REQ-007 SHALL have port pred_target, output, 32, the predicted next PC for fetch_pc.
REQ-008 SHALL have port ex_valid, input, 1, meaning an instruction is present in execute.
REQ-009 SHALL have port Cur_PC, input, PC_W, the execute-stage PC.
REQ-010 SHALL have port Imm, input, 32, the execute-stage immediate.
REQ-011 SHALL have ports Branch, JalrSel and HaltSel, each input, 1, marking the execute instruction as a conditional branch, a jump or a halt.
REQ-012 SHALL have port AluResult, input, 32; bit 0 is the branch condition and the full value is the jalr target.
REQ-013 SHALL have ports ex_pred_taken, input, 1, and ex_pred_target, input, 32: the prediction carried down the pipe with the execute instruction.
REQ-014 SHALL have ports PC_Imm and PC_Four, each output, 32: the sums Cur_PC+Imm and Cur_PC+4.
REQ-015 SHALL have ports BrPC, output, 32, the redirect PC, and PcSel, output, 1, the redirect request.
REQ-016 SHALL have ports br_count and mispred_count, each output, 32: performance counters.

Function
REQ-017 SHALL zero-extend Cur_PC to 32 bits (PCF); with HaltSel=1, PC_Imm and PC_Four SHALL both equal PCF.
REQ-018 SHALL hold, per entry, a valid bit, a tag of PC_W-IDX_W-2 bits, a 32-bit target and a 2-bit saturating counter.
REQ-019 SHALL take the table index from PC[IDX_W+1:2] and the tag from PC[PC_W-1:IDX_W+2].
REQ-020 SHALL form the prediction combinationally from the registered table: hit = valid AND tag match; pred_taken = hit AND counter[1].
REQ-021 SHALL drive pred_target = stored target when pred_taken=1, else {zero-extended fetch_pc}+4.
REQ-022 SHALL compute actual_taken = HaltSel OR JalrSel OR (Branch AND AluResult[0]).
REQ-023 SHALL compute actual_target with priority HaltSel -> PCF, JalrSel -> AluResult, taken branch -> PC_Imm, otherwise PC_Four.
REQ-024 SHALL assert mispredict only when ex_valid=1 and (actual_taken != ex_pred_taken, or actual_taken=1 with ex_pred_target != actual_target).
REQ-025 SHALL drive PcSel = (ex_valid AND HaltSel) OR mispredict, and BrPC = actual_target; BrPC and PcSel are combinational.
REQ-026 SHALL update the table at the clock edge only when ex_valid=1, HaltSel=0 and (Branch OR JalrSel).
REQ-027 SHALL, on update with a hit, set the counter to 11 for a jump, otherwise increment it if taken and decrement it if not taken, saturating at 11 and 00; taken updates also rewrite the target.
REQ-028 SHALL, on update with a miss and actual_taken=1, allocate the entry: valid=1, write tag and target, counter 10 for a branch or 11 for a jump; a not-taken miss leaves the entry unchanged.
REQ-029 SHALL, when fetch_pc and Cur_PC index the same entry in one cycle, give the prediction from the pre-update contents; the write is visible from the next cycle.
REQ-030 SHALL increment br_count on every update cycle and mispred_count on every cycle with mispredict=1; both wrap modulo 2^32.
REQ-031 SHALL, with HaltSel=1, freeze the table and both counters, and hold PcSel=1 with BrPC=PCF every cycle ex_valid=1.

Reset
REQ-032 SHALL, at a clock edge with reset_n=0, clear all valid bits, set all counters to 01 and zero br_count and mispred_count, even mid-update; reset takes priority over any update.
REQ-033 SHALL keep BrPC, PcSel, PC_Imm, PC_Four, pred_taken and pred_target purely combinational during reset; after reset, pred_taken=0 for every fetch_pc.

Verification
REQ-034 SHALL cover: after reset, fetch_pc=0x040 -> pred_taken=0, pred_target=0x44.
REQ-035 SHALL cover: branch at 0x040, Imm=0x20, AluResult=1, ex_pred_taken=0 -> PcSel=1, BrPC=0x60, mispred_count=1; next cycle fetch_pc=0x040 -> pred_taken=1, pred_target=0x60.
REQ-036 SHALL cover: the same branch resolved not-taken twice -> counter 10->01->00 and pred_taken=0; the first resolution redirects with BrPC=0x44.
REQ-037 SHALL cover: jalr at 0x080 with AluResult=0x1C and ex_pred_target=0x18 -> mispredict, BrPC=0x1C, and the entry's target is rewritten to 0x1C.
REQ-038 SHALL cover: HaltSel=1 at 0x0F0 -> PcSel=1, BrPC=0xF0, PC_Four=0xF0, no table or counter change.
REQ-039 SHALL cover: reset_n=0 asserted during an update cycle -> no allocation, both counters 0.
